rti_issue_ctrl: RTL and testbench
=================================

# rti_issue_ctrl

CPU-side issue/collect controller for the ray-triangle intersection accelerator. It accepts up to 15 FP32 operand writes from the core, one per handshake. On a launch command it presents all 15 operands to the accelerator with a single-cycle valid pulse. It then waits for the accelerator's result-valid pulse and holds the 32-bit result on a valid/ready response channel until the core consumes it.

## Interface
Parameters:
- NUM_OPS, 15, operand slot count; must match the accelerator's register count.
- DATA_W, 32, operand/result width.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; only used with RTI_TIMEOUT_EN.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- wr_valid_i  in  1  operand write request.
- wr_ready_o  out  1  operand write accepted when wr_valid_i && wr_ready_o.
- wr_idx_i  in  4  operand slot index.
- wr_data_i  in  DATA_W  operand value.
- clr_i  in  1  clears the written-slot mask; honoured only in LOAD.
- cmd_valid_i  in  1  launch request.
- cmd_ready_o  out  1  launch accepted when cmd_valid_i && cmd_ready_o.
- acc_regs_o  out  NUM_OPS×DATA_W  operand bank, driven directly from registers.
- acc_valid_o  out  1  one-cycle launch pulse to the accelerator.
- acc_result_i  in  DATA_W  accelerator result.
- acc_valid_i  in  1  accelerator result-valid pulse.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  core consumes the response.
- rsp_data_o  out  DATA_W  result value, or error code.
- rsp_err_o  out  1  response is an error.
- busy_o  out  1  high in ISSUE, WAIT and RESP.
- fault_o  out  1  sticky watchdog fault; tied 0 without the macro.

## Operation
- States: LOAD, ISSUE, WAIT, RESP.
- **LOAD** handshakes:
  - wr_ready_o = (state==LOAD) && !cmd_valid_i, so a launch has priority over a same-cycle write.
  - An accepted write with wr_idx_i < NUM_OPS stores wr_data_i in slot wr_idx_i and sets mask[wr_idx_i].
  - An accepted write with wr_idx_i ≥ NUM_OPS is consumed and discarded; the mask is unchanged.
  - cmd_ready_o = (state==LOAD).
- **Launch from LOAD:**
  - Mask all ones and fault_o=0 → ISSUE.
  - Otherwise → RESP with rsp_err_o=1 and rsp_data_o=32'h0000_0001 (incomplete operands) or 32'h0000_0002 (fault).
- **clr_i in LOAD:** mask ← 0; operand values are kept. clr_i has priority over a same-cycle write's mask bit.
- **Mask persistence:** the mask persists across launches, so the core can rewrite only the ray slots and relaunch.
- **ISSUE:** acc_valid_o=1 for exactly this cycle → WAIT. acc_regs_o is stable from ISSUE until the next accepted write.
- **WAIT:** on acc_valid_i, capture acc_result_i into rsp_data_o with rsp_err_o=0 → RESP.
- **Outside WAIT:** acc_valid_i is ignored in LOAD, ISSUE and RESP.
- **RESP:** rsp_valid_o=1. On rsp_ready_i → LOAD. rsp_data_o and rsp_err_o are stable while rsp_valid_o is high.

## Timing
- **Reset:** in the cycle after rst is sampled high:
  - state=LOAD, mask=0, all operands 0.
  - acc_valid_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0, fault_o=0.
  - wr_ready_o and cmd_ready_o are then 1 (subject to cmd_valid_i for wr_ready_o).
- **Reset mid-operation:** any pending result is dropped. A later acc_valid_i lands in LOAD and is ignored.
- **Launch latency:**
  - cmd accepted in cycle N → acc_valid_o high in N+1 → WAIT from N+2.
  - acc_valid_i in cycle K → rsp_valid_o high in K+1.
  - Minimum round trip is launch + 3 cycles plus the accelerator latency.
- **Error path:** launch accepted in cycle N → rsp_valid_o high in N+1.
- **Response handshake:** rsp_ready_i high in the same cycle rsp_valid_o rises completes the handshake; the next cycle is LOAD.
- **Back-to-back writes:** one write per cycle is sustained in LOAD.

## Configuration
- Macro: RTI_TIMEOUT_EN.
- **Defined:**
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - At count == TIMEOUT_CYCLES-1 without acc_valid_i → RESP with rsp_err_o=1 and rsp_data_o=32'hFFFF_FFFF, and fault_o is set.
  - fault_o is cleared only by rst. While it is set, launches return error 2.
  - acc_valid_i in the same cycle as the expiry wins; the result is returned normally.
- **Undefined:** WAIT lasts indefinitely; fault_o=0; no counter is synthesised.

## Structure
- Package rti_pkg holds:
  - NUM_OPS and DATA_W constants.
  - the rti_state_t enum (LOAD/ISSUE/WAIT/RESP).
  - error-code constants RTI_ERR_INCOMPLETE=1, RTI_ERR_FAULT=2, RTI_ERR_TIMEOUT=32'hFFFF_FFFF.
- Sub-module rti_watchdog: counter plus expiry flag, instantiated only under RTI_TIMEOUT_EN.

## Test plan
- Write slots 0..14 with 32'h3F80_0000+i, then launch → one acc_valid_o pulse with acc_regs_o[i] correct; acc_valid_i after 40 cycles with 32'h4120_0000 → rsp_data_o=32'h4120_0000, rsp_err_o=0.
- Write only slots 0..13, then launch → rsp_err_o=1, rsp_data_o=1 one cycle later; acc_valid_o never asserts.
- Full load, launch, then rewrite slots 3..5 only and relaunch → second launch issues, and acc_regs_o shows the new slots 3..5 with the old values elsewhere.
- Assert rst during WAIT, then pulse acc_valid_i → rsp_valid_o stays 0, state is LOAD, mask=0.
- Hold rsp_ready_i low for 10 cycles in RESP → rsp_data_o stable; writes are not accepted (wr_ready_o=0).
- With RTI_TIMEOUT_EN and TIMEOUT_CYCLES=16, give no acc_valid_i → response 32'hFFFF_FFFF with err=1 at WAIT-entry+16, fault_o=1; the next launch returns error 2.

Source files
------------

// File: rtl/rti_pkg.sv
// Shared constants, state encoding and response error codes for the
// ray-triangle intersection issue/collect controller.
package rti_pkg;

  localparam int NUM_OPS        = 15;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    LOAD,
    ISSUE,
    WAIT,
    RESP
  } rti_state_t;

  localparam logic [31:0] RTI_ERR_INCOMPLETE = 32'h0000_0001;
  localparam logic [31:0] RTI_ERR_FAULT      = 32'h0000_0002;
  localparam logic [31:0] RTI_ERR_TIMEOUT    = 32'hFFFF_FFFF;

endpackage

// File: rtl/rti_watchdog.sv
// WAIT-state watchdog: counts cycles while run is high and flags the final
// cycle of the allowed window. Only instantiated under RTI_TIMEOUT_EN.
module rti_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Leaving WAIT zeroes the count, so every WAIT entry starts from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rti_issue_ctrl.sv
// Issue/collect controller: gathers operand writes, launches the accelerator
// with a one-cycle pulse and returns its result. Optional watchdog: RTI_TIMEOUT_EN.
module rti_issue_ctrl #(
  parameter int NUM_OPS        = rti_pkg::NUM_OPS,
  parameter int DATA_W         = rti_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = rti_pkg::TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [3:0]                wr_idx_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic                      clr_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  output logic [NUM_OPS*DATA_W-1:0] acc_regs_o,
  output logic                      acc_valid_o,
  input  logic [DATA_W-1:0]         acc_result_i,
  input  logic                      acc_valid_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic                      fault_o
);

  import rti_pkg::*;

  rti_state_t          state;
  rti_state_t          state_next;
  logic [DATA_W-1:0]   ops [NUM_OPS];
  logic [NUM_OPS-1:0]  mask;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic                wr_fire;
  logic                cmd_fire;
  logic                launch_ok;
  logic                fault;
  logic                expired;

  assign wr_fire   = wr_valid_i && wr_ready_o;
  assign cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign launch_ok = (&mask) && !fault;

`ifdef RTI_TIMEOUT_EN
  rti_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    (state == WAIT),
    .expired(expired)
  );

  // A result arriving on the expiry cycle wins, so no fault is recorded then.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (state == WAIT && expired && !acc_valid_i) begin
      fault <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
  assign fault   = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (cmd_fire) state_next = launch_ok ? ISSUE : RESP;
      ISSUE:   state_next = WAIT;
      WAIT:    if (acc_valid_i || expired) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // A pending launch blocks writes so the issued bank matches what was checked.
  always_comb begin
    wr_ready_o  = (state == LOAD) && !cmd_valid_i;
    cmd_ready_o = (state == LOAD);
    acc_valid_o = (state == ISSUE);
    rsp_valid_o = (state == RESP);
    busy_o      = (state != LOAD);
  end

  // Out-of-range indices match no slot and are dropped; clear overrides a
  // same-cycle write's mask bit because it is assigned last.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        ops[i] <= '0;
      end
      mask <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (wr_fire && wr_idx_i == 4'(i)) begin
          ops[i]  <= wr_data_i;
          mask[i] <= 1'b1;
        end
      end
      if (state == LOAD && clr_i) begin
        mask <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (cmd_fire && !launch_ok) begin
            rsp_err  <= 1'b1;
            rsp_data <= fault ? DATA_W'(RTI_ERR_FAULT) : DATA_W'(RTI_ERR_INCOMPLETE);
          end
        end
        WAIT: begin
          if (acc_valid_i) begin
            rsp_err  <= 1'b0;
            rsp_data <= acc_result_i;
          end else if (expired) begin
            rsp_err  <= 1'b1;
            rsp_data <= DATA_W'(RTI_ERR_TIMEOUT);
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_bank
    assign acc_regs_o[g*DATA_W +: DATA_W] = ops[g];
  end

  assign rsp_data_o = rsp_data;
  assign rsp_err_o  = rsp_err;
  assign fault_o    = fault;

endmodule

// File: tb/tb_rti_issue_ctrl.sv
// Directed bench for rti_issue_ctrl; the watchdog section runs only when
// RTI_TIMEOUT_EN is defined (TIMEOUT_CYCLES is set to 16 here).
module tb_rti_issue_ctrl;

  localparam int NUM_OPS = 15;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst;
  logic                      wr_valid_i;
  logic                      wr_ready_o;
  logic [3:0]                wr_idx_i;
  logic [DATA_W-1:0]         wr_data_i;
  logic                      clr_i;
  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic [NUM_OPS*DATA_W-1:0] acc_regs_o;
  logic                      acc_valid_o;
  logic [DATA_W-1:0]         acc_result_i;
  logic                      acc_valid_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [DATA_W-1:0]         rsp_data_o;
  logic                      rsp_err_o;
  logic                      busy_o;
  logic                      fault_o;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  rti_issue_ctrl #(
    .NUM_OPS       (NUM_OPS),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_idx_i    (wr_idx_i),
    .wr_data_i   (wr_data_i),
    .clr_i       (clr_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .acc_regs_o  (acc_regs_o),
    .acc_valid_o (acc_valid_o),
    .acc_result_i(acc_result_i),
    .acc_valid_i (acc_valid_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .fault_o     (fault_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [31:0] slot(int i);
    return acc_regs_o[i*DATA_W +: DATA_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] idx, input logic [31:0] data);
    wr_valid_i = 1'b1;
    wr_idx_i   = idx;
    wr_data_i  = data;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic launch();
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_valid_i = 1'b0; wr_idx_i = '0; wr_data_i = '0; clr_i = 1'b0;
    cmd_valid_i = 1'b0; acc_result_i = '0; acc_valid_i = 1'b0; rsp_ready_i = 1'b0;
    tick();
    tick();

    checkOutput("rst_busy",      32'(busy_o),      32'd0);
    checkOutput("rst_acc_valid", 32'(acc_valid_o), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_rsp_data",  rsp_data_o,       32'd0);
    checkOutput("rst_rsp_err",   32'(rsp_err_o),   32'd0);
    checkOutput("rst_fault",     32'(fault_o),     32'd0);
    checkOutput("rst_wr_ready",  32'(wr_ready_o),  32'd1);
    checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("rst_slot0",     slot(0),          32'd0);
    rst = 1'b0;

    acc_valid_i = 1'b1; acc_result_i = 32'hBAD0_0001;
    tick();
    acc_valid_i = 1'b0;
    checkOutput("load_ignores_acc_valid", 32'(rsp_valid_o), 32'd0);

    $display("[TB] full load and launch");
    for (int i = 0; i < NUM_OPS; i++) begin
      applyStimulus(4'(i), 32'h3F80_0000 + 32'(i));
    end
    wr_valid_i = 1'b1; wr_idx_i = 4'd0; wr_data_i = 32'hDEAD_BEEF;
    cmd_valid_i = 1'b1;
    #1;
    checkOutput("launch_blocks_write", 32'(wr_ready_o), 32'd0);
    tick();
    wr_valid_i = 1'b0; cmd_valid_i = 1'b0;
    checkOutput("issue_pulse",  32'(acc_valid_o), 32'd1);
    checkOutput("issue_busy",   32'(busy_o),      32'd1);
    checkOutput("issue_slot0",  slot(0),          32'h3F80_0000);
    checkOutput("issue_slot7",  slot(7),          32'h3F80_0007);
    checkOutput("issue_slot14", slot(14),         32'h3F80_000E);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (acc_valid_o || rsp_valid_o) pulses++;
    end
    checkOutput("wait_quiet_40", 32'(pulses), 32'd0);
    acc_valid_i = 1'b1; acc_result_i = 32'h4120_0000;
    tick();
    acc_valid_i = 1'b0; acc_result_i = '0;
    checkOutput("result_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("result_data",  rsp_data_o,       32'h4120_0000);
    checkOutput("result_err",   32'(rsp_err_o),   32'd0);

    $display("[TB] response held for 10 cycles");
    wr_valid_i = 1'b1; wr_idx_i = 4'd2; wr_data_i = 32'h0BAD_0BAD;
    for (int c = 0; c < 10; c++) begin
      acc_valid_i = (c == 4);
      acc_result_i = 32'h7777_7777;
      #1;
      checkOutput("resp_wr_ready", 32'(wr_ready_o), 32'd0);
      tick();
      checkOutput("resp_hold_data",  rsp_data_o,       32'h4120_0000);
      checkOutput("resp_hold_valid", 32'(rsp_valid_o), 32'd1);
    end
    wr_valid_i = 1'b0; acc_valid_i = 1'b0;
    consume();
    checkOutput("resp_done_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("resp_done_busy",  32'(busy_o),      32'd0);
    checkOutput("resp_slot2_kept", slot(2),          32'h3F80_0002);

    $display("[TB] partial rewrite and relaunch");
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(4'(i), 32'h4000_0000 + 32'(i));
    end
    launch();
    checkOutput("relaunch_pulse", 32'(acc_valid_o), 32'd1);
    checkOutput("relaunch_slot2", slot(2),          32'h3F80_0002);
    checkOutput("relaunch_slot3", slot(3),          32'h4000_0003);
    checkOutput("relaunch_slot5", slot(5),          32'h4000_0005);
    checkOutput("relaunch_slot6", slot(6),          32'h3F80_0006);
    tick();
    checkOutput("relaunch_wait", 32'(acc_valid_o), 32'd0);
    acc_valid_i = 1'b1; acc_result_i = 32'h1234_5678; rsp_ready_i = 1'b1;
    tick();
    acc_valid_i = 1'b0;
    checkOutput("fast_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("fast_rsp_data",  rsp_data_o,       32'h1234_5678);
    tick();
    rsp_ready_i = 1'b0;
    checkOutput("same_cycle_ready_load", 32'(busy_o), 32'd0);

    $display("[TB] clear and incomplete launches");
    clr_i = 1'b1;
    applyStimulus(4'd0, 32'h5555_0000);
    clr_i = 1'b0;
    checkOutput("clr_keeps_write", slot(0), 32'h5555_0000);
    checkOutput("clr_keeps_slot1", slot(1), 32'h3F80_0001);
    for (int i = 1; i <= 13; i++) begin
      applyStimulus(4'(i), 32'h4200_0000 + 32'(i));
    end
    applyStimulus(4'd15, 32'hFFFF_0000);
    checkOutput("oob_slot14_kept", slot(14), 32'h3F80_000E);
    launch();
    checkOutput("err1a_acc_valid", 32'(acc_valid_o), 32'd0);
    checkOutput("err1a_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("err1a_err",       32'(rsp_err_o),   32'd1);
    checkOutput("err1a_data",      rsp_data_o,       32'h0000_0001);
    consume();
    applyStimulus(4'd0, 32'h4200_0000);
    launch();
    checkOutput("err1b_acc_valid", 32'(acc_valid_o), 32'd0);
    checkOutput("err1b_err",       32'(rsp_err_o),   32'd1);
    checkOutput("err1b_data",      rsp_data_o,       32'h0000_0001);
    tick();
    checkOutput("err1b_still_no_pulse", 32'(acc_valid_o), 32'd0);
    consume();

    $display("[TB] reset during WAIT");
    applyStimulus(4'd14, 32'h4200_000E);
    launch();
    checkOutput("pre_reset_issue", 32'(acc_valid_o), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_valid_i = 1'b1; acc_result_i = 32'hCAFE_F00D;
    tick();
    acc_valid_i = 1'b0;
    checkOutput("post_reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("post_reset_busy",      32'(busy_o),      32'd0);
    checkOutput("post_reset_slot14",    slot(14),         32'd0);
    launch();
    checkOutput("post_reset_mask_err", 32'(rsp_err_o), 32'd1);
    checkOutput("post_reset_mask_code", rsp_data_o,   32'h0000_0001);
    consume();

`ifdef RTI_TIMEOUT_EN
    $display("[TB] watchdog expiry");
    for (int i = 0; i < NUM_OPS; i++) begin
      applyStimulus(4'(i), 32'h3F00_0000 + 32'(i));
    end
    launch();
    tick();
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (rsp_valid_o) pulses++;
    end
    checkOutput("wd_no_early_rsp", 32'(pulses), 32'd0);
    tick();
    checkOutput("wd_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("wd_rsp_err",   32'(rsp_err_o),   32'd1);
    checkOutput("wd_rsp_data",  rsp_data_o,       32'hFFFF_FFFF);
    checkOutput("wd_fault",     32'(fault_o),     32'd1);
    consume();
    launch();
    checkOutput("wd_fault_launch_pulse", 32'(acc_valid_o), 32'd0);
    checkOutput("wd_fault_launch_err",   32'(rsp_err_o),   32'd1);
    checkOutput("wd_fault_launch_code",  rsp_data_o,       32'h0000_0002);
    consume();
`else
    checkOutput("fault_tied_low", 32'(fault_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
